immgen_stage: RTL
=================

Name: immgen_stage

Overview:
- Registered, handshaked immediate-generation stage for the decode pipeline.
- Classifies the incoming instruction's format from its opcode and selects the sign-extended immediate.
- Presents the result through a 2-entry skid buffer, so full throughput holds under backpressure.
- Sits between fetch/instruction buffer and the decode/issue register; generalises the combinational five-output generator to XLEN 32/64, a single selected output with format tag, and optional RVC support.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64; immediates sign-extend to XLEN.
- ILEN, 32, instruction width; fixed at 32 (compressed encodings occupy instr[15:0]).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, synchronous, active-low.
- flush_i  input  1  drop all buffered entries (branch redirect).
- in_valid_i  input  1  instruction offered.
- in_ready_o  output  1  stage can accept.
- instr_i  input  ILEN  raw instruction.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts.
- imm_o  output  XLEN  selected, sign-extended immediate.
- fmt_o  output  3  imm_fmt_e: NONE, I, S, B, U, J, CI, CJ/CB (package enum).
- instr_o  output  ILEN  instruction passed along with its immediate.

Behaviour:
- Reset (rst_ni=0 at clock edge): out_valid_o=0, skid entry invalid, imm_o=0, fmt_o=NONE, instr_o=0. in_ready_o=1 from the first cycle after reset.
- Format decode on instr_i[6:0] when instr_i[1:0]==2'b11:
  - LUI 0110111, AUIPC 0010111 -> U.
  - JAL 1101111 -> J.
  - JALR 1100111, LOAD 0000011, OP-IMM 0010011, OP-IMM-32 0011011 (XLEN=64 only; NONE when XLEN=32), SYSTEM 1110011 -> I.
  - STORE 0100011 -> S.
  - BRANCH 1100011 -> B.
  - Anything else -> NONE, imm 0.
- Immediate bit layouts are the RISC-V base ISA I/S/B/U/J layouts. Bit 31 sign-extends to XLEN for all of them, including U on XLEN=64.
- Latency: 1 cycle. An instruction accepted at edge N is visible on outputs after edge N.
- Handshake:
  - Transfer on valid&&ready.
  - in_ready_o = !skid_valid (registered, no combinational path from out_ready_i).
  - out_valid_o must not drop and outputs must not change while out_valid_o && !out_ready_i.
- Skid buffer:
  - Output register empty or draining -> new entry goes to output register.
  - Output register stalled and input accepted -> entry goes to skid.
  - On output drain with skid valid -> skid moves to output register the same edge.
  - Order is strictly FIFO.
- Simultaneous accept and drain with skid empty -> output register reloads; no bubble.
- flush_i: at the edge, out_valid_o and the skid entry clear and any same-cycle input is discarded. Flush has priority over all transfers.
- Reset mid-stall clears both entries identically to flush.

Optional Feature:
- IMMGEN_RVC_EN defined: when instr_i[1:0]!=2'b11, decode quadrant/funct3:
  - C.ADDI/C.LI -> CI (imm = sext{instr[12],instr[6:2]}).
  - C.LUI (rd!=0,2) -> CI (imm = sext{instr[12],instr[6:2],12'b0}).
  - C.J/C.JAL -> CJ (11-bit scrambled offset, sext).
  - C.BEQZ/C.BNEZ -> CB (8-bit scrambled offset, sext).
  - Other compressed encodings -> NONE.
- IMMGEN_RVC_EN undefined: all compressed encodings -> NONE, imm 0; no RVC logic synthesised.

Decomposition:
- Package imm_pkg holds:
  - imm_fmt_e enum.
  - Opcode localparams (OPC_LUI, OPC_BRANCH, ...).
  - Pure functions imm_i/s/b/u/j(instr), parameterised by XLEN via explicit sign-extension width.
- Sub-module imm_select: combinational format decode + mux. Separating it lets the bench check it exhaustively against the package functions.

Test Plan:
- 0xFFF00093 (addi x1,x0,-1), XLEN=32 -> fmt I, imm 0xFFFFFFFF, one cycle later.
- 0x123450B7 (lui) -> U, 0x12345000; with XLEN=64 0x800000B7 -> 0xFFFFFFFF80000000.
- 0xFE000EE3 (beq -4) -> B, 0xFFFFFFFC; 0x0080006F (jal +8) -> J, 0x00000008; 0x0000000B -> NONE, 0.
- Three back-to-back valid instructions, out_ready_i=0 for 3 cycles:
  - First two accepted; in_ready_o low from the second accept onward.
  - Outputs stable while stalled.
  - Releasing out_ready_i drains in order with no bubble.
  - Third is accepted once the skid empties.
- Both entries full, flush_i=1 with in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1, no stale output later.
- With IMMGEN_RVC_EN: 0x0000107D (c.addi x0,-1) -> CI, 0xFFFFFFFF. Without the macro, same stimulus -> NONE, 0.

Source files
------------

// File: rtl/imm_pkg.sv
// Immediate formats, base opcodes and 64-bit sign-extended immediate builders.
// RVC builders exist only when IMMGEN_RVC_EN is defined.
package imm_pkg;

  localparam int MAX_XLEN = 64;

  // CJ and CB share one code; the immediate itself tells jump from branch offsets.
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_CI   = 3'd6,
    FMT_CJB  = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;

  typedef logic [MAX_XLEN-1:0] imm_t;

  // Builders sign-extend to MAX_XLEN; truncating the low XLEN bits keeps the sign.
  function automatic imm_t imm_i(input logic [31:0] instr);
    return {{52{instr[31]}}, instr[31:20]};
  endfunction

  function automatic imm_t imm_s(input logic [31:0] instr);
    return {{52{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic imm_t imm_b(input logic [31:0] instr);
    return {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic imm_t imm_u(input logic [31:0] instr);
    return {{32{instr[31]}}, instr[31:12], 12'b0};
  endfunction

  function automatic imm_t imm_j(input logic [31:0] instr);
    return {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

`ifdef IMMGEN_RVC_EN
  function automatic imm_t imm_ci(input logic [31:0] instr);
    return {{58{instr[12]}}, instr[12], instr[6:2]};
  endfunction

  function automatic imm_t imm_clui(input logic [31:0] instr);
    return {{46{instr[12]}}, instr[12], instr[6:2], 12'b0};
  endfunction

  function automatic imm_t imm_cj(input logic [31:0] instr);
    return {{52{instr[12]}}, instr[12], instr[8], instr[10:9], instr[6], instr[7],
            instr[2], instr[11], instr[5:3], 1'b0};
  endfunction

  function automatic imm_t imm_cb(input logic [31:0] instr);
    return {{55{instr[12]}}, instr[12], instr[6:5], instr[2], instr[11:10],
            instr[4:3], 1'b0};
  endfunction
`endif

endpackage

// File: rtl/imm_select.sv
// Combinational format decode and immediate mux for one instruction.
// Compressed decode is present only with IMMGEN_RVC_EN defined.
module imm_select
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o
);

  imm_fmt_e fmt;
  imm_t     imm_full;
  logic     imm_hi_unused;

  always_comb begin
    fmt      = FMT_NONE;
    imm_full = '0;
    if (instr_i[1:0] == 2'b11) begin
      case (instr_i[6:0])
        OPC_LUI, OPC_AUIPC: begin
          fmt      = FMT_U;
          imm_full = imm_u(instr_i);
        end
        OPC_JAL: begin
          fmt      = FMT_J;
          imm_full = imm_j(instr_i);
        end
        OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM: begin
          fmt      = FMT_I;
          imm_full = imm_i(instr_i);
        end
        OPC_OP_IMM32: begin
          if (XLEN == 64) begin
            fmt      = FMT_I;
            imm_full = imm_i(instr_i);
          end
        end
        OPC_STORE: begin
          fmt      = FMT_S;
          imm_full = imm_s(instr_i);
        end
        OPC_BRANCH: begin
          fmt      = FMT_B;
          imm_full = imm_b(instr_i);
        end
        default: begin
          fmt      = FMT_NONE;
          imm_full = '0;
        end
      endcase
    end
`ifdef IMMGEN_RVC_EN
    else if (instr_i[1:0] == 2'b01) begin
      case (instr_i[15:13])
        3'b000, 3'b010: begin
          fmt      = FMT_CI;
          imm_full = imm_ci(instr_i);
        end
        // rd==2 in this slot is C.ADDI16SP, which is not a CI immediate here
        3'b011: begin
          if (instr_i[11:7] != 5'd0 && instr_i[11:7] != 5'd2) begin
            fmt      = FMT_CI;
            imm_full = imm_clui(instr_i);
          end
        end
        // funct3 001 is C.JAL only on RV32; RV64 reuses it for C.ADDIW
        3'b001: begin
          if (XLEN == 32) begin
            fmt      = FMT_CJB;
            imm_full = imm_cj(instr_i);
          end
        end
        3'b101: begin
          fmt      = FMT_CJB;
          imm_full = imm_cj(instr_i);
        end
        3'b110, 3'b111: begin
          fmt      = FMT_CJB;
          imm_full = imm_cb(instr_i);
        end
        default: begin
          fmt      = FMT_NONE;
          imm_full = '0;
        end
      endcase
    end
`endif
  end

  assign imm_o         = imm_full[XLEN-1:0];
  assign fmt_o         = fmt;
  assign imm_hi_unused = ^imm_full;

endmodule

// File: rtl/immgen_stage.sv
// Registered immediate-generation stage with a 2-entry skid buffer.
// Define IMMGEN_RVC_EN to decode compressed immediates.
module immgen_stage
  import imm_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [ILEN-1:0] instr_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic [ILEN-1:0] instr_o
);

  logic [XLEN-1:0] sel_imm;
  logic [2:0]      sel_fmt;

  imm_select #(.XLEN(XLEN)) u_imm_select (
    .instr_i (instr_i),
    .imm_o   (sel_imm),
    .fmt_o   (sel_fmt)
  );

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  logic [2:0]      out_fmt_q, out_fmt_d;
  logic [ILEN-1:0] out_instr_q, out_instr_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  logic [2:0]      skid_fmt_q, skid_fmt_d;
  logic [ILEN-1:0] skid_instr_q, skid_instr_d;

  logic accept;
  logic out_free;

  assign accept   = in_valid_i && !skid_valid_q;
  assign out_free = !out_valid_q || out_ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_fmt_d    = out_fmt_q;
    out_instr_d  = out_instr_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;
    skid_instr_d = skid_instr_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      // A held skid entry is older than anything at the input, so it goes first
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_fmt_d    = skid_fmt_q;
        out_instr_d  = skid_instr_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_imm_d   = sel_imm;
        out_fmt_d   = sel_fmt;
        out_instr_d = instr_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = sel_imm;
      skid_fmt_d   = sel_fmt;
      skid_instr_d = instr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_fmt_q    <= FMT_NONE;
      out_instr_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= FMT_NONE;
      skid_instr_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_fmt_q    <= out_fmt_d;
      out_instr_q  <= out_instr_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_fmt_q   <= skid_fmt_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  assign in_ready_o  = !skid_valid_q;
  assign out_valid_o = out_valid_q;
  assign imm_o       = out_imm_q;
  assign fmt_o       = out_fmt_q;
  assign instr_o     = out_instr_q;

endmodule
